switch_debounce: RTL and testbench
==================================

# switch_debounce

Multi-channel debouncer and edge detector for the slide-switch and pushbutton inputs on the board. It sits directly upstream of the latch and flip-flop stages. It turns raw, bouncing `SW` levels into clean, `Clk`-synchronous levels and single-cycle edge pulses, so that a downstream flip-flop's `D` and clock-enable see exactly one transition per physical switch throw.

## Interface
- `WIDTH`, default 2: number of independent switch channels.
- `CNT_MAX`, default 500000: number of consecutive stable `Clk` cycles needed to accept a new level (10 ms at 50 MHz). Must be ≥ 1.
- `CNT_W`, default 20: width of each channel counter. Must satisfy `CNT_MAX` < 2^`CNT_W`.

Ports:
- `Clk`  in  1: single system clock; all state is updated on its rising edge.
- `Resetn`  in  1: reset, asynchronous, active-low.
- `SW_in`  in  `WIDTH`: raw switch levels, asynchronous to `Clk`.
- `Q`  out  `WIDTH`: debounced level per channel, registered.
- `Rise`  out  `WIDTH`: one-cycle pulse when `Q[i]` goes 0→1, registered.
- `Fall`  out  `WIDTH`: one-cycle pulse when `Q[i]` goes 1→0, registered.
- `Toggle`  out  `WIDTH`: present only when `SWDB_TOGGLE_EN` is defined (see Configuration).

## Operation
- Each channel is fully independent. There is no shared state except `Clk` and `Resetn`.
- Synchronizer: two flops, `s1[i] <= SW_in[i]` and `s2[i] <= s1[i]`. Only `s2` feeds the logic below.
- Per-channel FSM has two states:
  - STABLE: `s2[i] == Q[i]` and `cnt[i] == 0`.
  - PENDING: `s2[i] != Q[i]`. Each edge spent in PENDING increments `cnt[i]`.
- Transitions:
  - STABLE→PENDING on the first edge where `s2[i] != Q[i]`. On that edge `cnt` becomes 1.
  - PENDING→STABLE without change on any edge where `s2[i] == Q[i]`. `cnt` is cleared to 0. This is the glitch or bounce case.
  - PENDING→STABLE with acceptance on the edge where `s2[i] != Q[i]` and `cnt[i] == CNT_MAX-1`. On that edge: `Q[i] <= s2[i]`, `cnt[i] <= 0`, and `Rise[i]` or `Fall[i] <= 1` according to the direction of the change.
- `Rise` and `Fall` are cleared on every other edge, so each pulse is exactly one cycle wide. `Rise[i]` and `Fall[i]` are never both 1.
- `cnt` never exceeds `CNT_MAX-1`, so it cannot wrap.
- With `CNT_MAX` = 1, `Q` follows `s2` one edge later, and every accepted change still pulses.

## Timing
- Reset values, applied immediately on `Resetn` low regardless of `Clk`:
  - `s1`, `s2`, `Q`, `Rise`, `Fall`, `Toggle`, `cnt`: all 0.
  - FSM: STABLE.
- Latency for a clean step that is set up before edge 1:
  - `s2` changes at edge 2.
  - `Q`, `Rise`/`Fall` update at edge 2+`CNT_MAX`.
- A pulse shorter than `CNT_MAX` cycles at `s2` produces no output activity.
- Simultaneous changes on several channels are accepted in the same cycle when their counts complete together. Pulses on different channels may coincide.
- Reset mid-count discards any pending count. After release, an input already high needs a full 2+`CNT_MAX` edges and then produces `Rise`, because `Q` restarts at 0.
- `Resetn` deassertion is assumed synchronous to `Clk` at board level. No internal reset synchronizer is included.

## Configuration
- `SWDB_TOGGLE_EN` defined:
  - Adds output `Toggle [WIDTH-1:0]`, registered, reset 0.
  - `Toggle[i]` inverts on every edge where `Rise[i]` is set, so it becomes visible the cycle after the pulse.
  - Turns a pushbutton into an on/off latch.
- `SWDB_TOGGLE_EN` undefined: no `Toggle` port and no toggle flops. All other behaviour is identical.

## Test plan
All scenarios use `WIDTH`=2, `CNT_MAX`=4, and edge numbers counted from the first edge with the stimulus present.

1. Reset: hold `Resetn`=0 with `SW_in`=2'b11 → `Q`=00, `Rise`=`Fall`=00 throughout. Release `Resetn` → `Q`=11 and `Rise`=11 for one cycle at edge 6.
2. Clean step: from `Q`=00, drive `SW_in[0]` 0→1 → `Q[0]`=1 at edge 6, `Rise`=01 for exactly one cycle, `Fall`=00, `cnt` back to 0.
3. Glitch and bounce:
   - `SW_in[0]` high for 3 cycles, then low → `Q` and pulses unchanged.
   - `SW_in[0]` alternating every 2 cycles for 12 cycles, then held 1 → exactly one `Rise[0]`, 6 edges after the last transition.
4. Simultaneous: with `Q`=10, drive `SW_in`=10→01 on one edge → at edge 6 `Q`=01, `Rise`=01, `Fall`=10 in the same cycle.
5. Reset mid-operation: `SW_in[1]` 0→1, assert `Resetn`=0 after edge 4 → `Q`, `cnt`, and pulses are 0 immediately. Release with the input still 1 → `Rise[1]` 6 edges later.
6. With `SWDB_TOGGLE_EN`: three separate clean presses on `SW_in[0]` → `Toggle[0]` goes 1, 0, 1, each change landing one cycle after the corresponding `Rise[0]`. `Toggle[1]` stays 0.

Source files
------------

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer with registered level and single-cycle edge pulses.
// Optional SWDB_TOGGLE_EN adds a per-channel Toggle latch that flips after each Rise.
module switch_debounce #(
  parameter int WIDTH   = 2,
  parameter int CNT_MAX = 500000,
  parameter int CNT_W   = 20
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] SW_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Rise,
  output logic [WIDTH-1:0] Fall
`ifdef SWDB_TOGGLE_EN
  ,
  output logic [WIDTH-1:0] Toggle
`endif
);

  typedef enum logic {STABLE, PENDING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] change;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  state_t           state_q [WIDTH];
  state_t           state_d [WIDTH];

  // Two-flop synchronizer; only s2 is used past this point.
  always_comb begin
    s1_d = SW_in;
    s2_d = s1_q;
  end

  assign change = s2_q ^ q_q;

  always_comb begin
    q_d    = q_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          if (change[i]) begin
            // Only reachable with CNT_MAX == 1: accept on the first differing edge.
            if (cnt_q[i] == CNT_LAST) begin
              q_d[i]    = s2_q[i];
              rise_d[i] = s2_q[i];
              fall_d[i] = ~s2_q[i];
              cnt_d[i]  = '0;
            end else begin
              state_d[i] = PENDING;
              cnt_d[i]   = CNT_ONE;
            end
          end
        end
        PENDING: begin
          if (!change[i]) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
            q_d[i]     = s2_q[i];
            rise_d[i]  = s2_q[i];
            fall_d[i]  = ~s2_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      s1_q   <= '0;
      s2_q   <= '0;
      q_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= STABLE;
      end
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      q_q    <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i]   <= cnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign Q    = q_q;
  assign Rise = rise_q;
  assign Fall = fall_q;

`ifdef SWDB_TOGGLE_EN
  logic [WIDTH-1:0] toggle_q, toggle_d;

  // Flips on the edge that sees a registered Rise, so it lands a cycle after the pulse.
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign Toggle = toggle_q;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (WIDTH=2, CNT_MAX=4): expected accept events
// are queued when the stimulus is driven and compared when their cycle arrives.
module tb_switch_debounce;

   logic       clk;
   logic       Resetn;
   logic [1:0] SW_in;
   logic [1:0] Q;
   logic [1:0] Rise;
   logic [1:0] Fall;
`ifdef SWDB_TOGGLE_EN
   logic [1:0] Toggle;
`endif

   typedef struct {
      int         cyc;
      logic [1:0] q;
      logic [1:0] rise;
      logic [1:0] fall;
      string      tag;
   } ev_t;

   ev_t        evQ[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [1:0] qExp = '0;
   logic [1:0] prevRise = '0;
   logic [1:0] toggleExp = '0;

   switch_debounce #(
      .WIDTH(2),
      .CNT_MAX(4),
      .CNT_W(3)
   ) dut (
      .Clk(clk),
      .Resetn(Resetn),
      .SW_in(SW_in),
      .Q(Q),
      .Rise(Rise),
      .Fall(Fall)
`ifdef SWDB_TOGGLE_EN
      ,
      .Toggle(Toggle)
`endif
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global time bound so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("[TB] FAIL %s obs=%0h exp=%0h at cycle %0d", tag, obs, expv, cyc);
      end
   endtask

   task automatic pushEvent(input int dly, input logic [1:0] q, input logic [1:0] r,
                            input logic [1:0] f, input string tag);
      ev_t e;
      e.cyc  = cyc + dly;
      e.q    = q;
      e.rise = r;
      e.fall = f;
      e.tag  = tag;
      evQ.push_back(e);
   endtask

   // Compares outputs every cycle: a queued event when due, otherwise held Q and no pulses.
   task automatic monitor();
      logic [1:0] er;
      logic [1:0] ef;
      string      tag;
      ev_t        e;
      if (!Resetn) begin
         qExp      = '0;
         prevRise  = '0;
         toggleExp = '0;
         checkOutput("rst_q", {6'd0, Q}, 8'd0);
         checkOutput("rst_pulse", {4'd0, Rise, Fall}, 8'd0);
`ifdef SWDB_TOGGLE_EN
         checkOutput("rst_toggle", {6'd0, Toggle}, 8'd0);
`endif
         return;
      end
      toggleExp = toggleExp ^ prevRise;
      er  = '0;
      ef  = '0;
      tag = "idle";
      if (evQ.size() > 0 && evQ[0].cyc == cyc) begin
         e    = evQ.pop_front();
         qExp = e.q;
         er   = e.rise;
         ef   = e.fall;
         tag  = e.tag;
      end
      checkOutput({tag, "_q"}, {6'd0, Q}, {6'd0, qExp});
      checkOutput({tag, "_rise"}, {6'd0, Rise}, {6'd0, er});
      checkOutput({tag, "_fall"}, {6'd0, Fall}, {6'd0, ef});
`ifdef SWDB_TOGGLE_EN
      checkOutput({tag, "_toggle"}, {6'd0, Toggle}, {6'd0, toggleExp});
`endif
      prevRise = er;
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         monitor();
      end
   endtask

   // Drives a clean level change and schedules its acceptance 2+CNT_MAX edges later.
   task automatic applyStimulus(input logic [1:0] sw, input logic [1:0] q, input logic [1:0] r,
                                input logic [1:0] f, input string tag);
      SW_in = sw;
      pushEvent(6, q, r, f, tag);
      tick(10);
   endtask

   initial begin
      Resetn = 1'b0;
      SW_in  = 2'b11;
      tick(5);

      // Release with inputs high: both channels rise at edge 6.
      Resetn = 1'b1;
      pushEvent(6, 2'b11, 2'b11, 2'b00, "rst_release");
      tick(10);

      applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, "fall_both");
      applyStimulus(2'b01, 2'b01, 2'b01, 2'b00, "clean_rise0");

      // Three-cycle glitches on both channels must be ignored.
      SW_in = 2'b10;
      tick(3);
      SW_in = 2'b01;
      tick(10);

      applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, "clean_fall0");

      // Bounce: alternate every 2 cycles for 12 cycles, then hold high.
      for (int s = 0; s < 6; s++) begin
         SW_in = (s % 2 == 0) ? 2'b01 : 2'b00;
         tick(2);
      end
      SW_in = 2'b01;
      pushEvent(6, 2'b01, 2'b01, 2'b00, "bounce");
      tick(12);

      applyStimulus(2'b10, 2'b10, 2'b10, 2'b01, "swap_to10");
      applyStimulus(2'b01, 2'b01, 2'b01, 2'b10, "swap_to01");

      // Reset in the middle of a pending count on channel 1.
      SW_in = 2'b11;
      tick(4);
      #1;
      Resetn = 1'b0;
      evQ.delete();
      #1;
      checkOutput("async_rst_q", {6'd0, Q}, 8'd0);
      checkOutput("async_rst_pulse", {4'd0, Rise, Fall}, 8'd0);
      @(negedge clk);
      tick(3);
      Resetn = 1'b1;
      pushEvent(6, 2'b11, 2'b11, 2'b00, "midrst_release");
      tick(10);

      // Three separate presses on channel 0.
      applyStimulus(2'b00, 2'b00, 2'b00, 2'b11, "press_setup");
      for (int p = 0; p < 3; p++) begin
         applyStimulus(2'b01, 2'b01, 2'b01, 2'b00, "press");
         applyStimulus(2'b00, 2'b00, 2'b00, 2'b01, "release");
      end

      checkOutput("sb_empty", evQ.size()[7:0], 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
